// File: rtl/dmi_pkg.sv
// Shared types for the DMI target: request ops, response codes, FSM states
// and the default bus widths.
package dmi_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    RESP_SUCCESS = 2'd0,
    RESP_FAILED  = 2'd2
  } dmi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } dmi_state_e;

endpackage

// File: rtl/dmi_target_fsm.sv
// DMI request -> single debug-module register access -> DMI response, one at a time.
// Optional completion-wait timeout enabled by defining DMI_TIMEOUT_EN.
module dmi_target_fsm
  import dmi_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmi_req_valid,
  output logic              dmi_req_ready,
  input  logic [ADDR_W-1:0] dmi_req_addr,
  input  logic [1:0]        dmi_req_op,
  input  logic [DATA_W-1:0] dmi_req_data,
  output logic              dmi_resp_valid,
  input  logic              dmi_resp_ready,
  output logic [1:0]        dmi_resp_resp,
  output logic [DATA_W-1:0] dmi_resp_data,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_wen,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_rerr
);

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("dmi_target_fsm: TIMEOUT must be at least 1");
  end

  dmi_state_e        r_state;
  logic              r_req_ready;
  logic              r_resp_valid;
  dmi_resp_e         r_resp;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_dm_req_valid;
  logic [ADDR_W-1:0] r_dm_addr;
  logic              r_dm_wen;
  logic [DATA_W-1:0] r_dm_wdata;

  logic w_req_fire;
  assign w_req_fire = dmi_req_valid & r_req_ready;

`ifdef DMI_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] r_wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_req_ready    <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp         <= RESP_SUCCESS;
      r_resp_data    <= '0;
      r_dm_req_valid <= 1'b0;
      r_dm_addr      <= '0;
      r_dm_wen       <= 1'b0;
      r_dm_wdata     <= '0;
`ifdef DMI_TIMEOUT_EN
      r_wait_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_req_ready <= 1'b0;
            r_dm_addr   <= dmi_req_addr;
            r_dm_wen    <= (dmi_req_op == OP_WRITE);
            r_dm_wdata  <= dmi_req_data;
            r_resp_data <= '0;
            case (dmi_req_op)
              OP_READ, OP_WRITE: begin
                r_dm_req_valid <= 1'b1;
                r_state        <= ST_ISSUE;
              end
              OP_NOP: begin
                r_resp_valid <= 1'b1;
                r_resp       <= RESP_SUCCESS;
                r_state      <= ST_RESP;
              end
              default: begin
                r_resp_valid <= 1'b1;
                r_resp       <= RESP_FAILED;
                r_state      <= ST_RESP;
              end
            endcase
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        // Valid is held until acceptance; completion is only looked at from WAIT.
        ST_ISSUE: begin
          if (dm_req_ready) begin
            r_dm_req_valid <= 1'b0;
            r_state        <= ST_WAIT;
`ifdef DMI_TIMEOUT_EN
            r_wait_cnt     <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (dm_rvalid) begin
            r_resp_valid <= 1'b1;
            r_resp       <= dm_rerr ? RESP_FAILED : RESP_SUCCESS;
            r_resp_data  <= (!r_dm_wen && !dm_rerr) ? dm_rdata : '0;
            r_state      <= ST_RESP;
          end
`ifdef DMI_TIMEOUT_EN
          else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_resp_valid <= 1'b1;
            r_resp       <= RESP_FAILED;
            r_resp_data  <= '0;
            r_state      <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (dmi_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmi_req_ready  = r_req_ready;
  assign dmi_resp_valid = r_resp_valid;
  assign dmi_resp_resp  = r_resp;
  assign dmi_resp_data  = r_resp_data;
  assign dm_req_valid   = r_dm_req_valid;
  assign dm_addr        = r_dm_addr;
  assign dm_wen         = r_dm_wen;
  assign dm_wdata       = r_dm_wdata;

endmodule

// File: tb/tb_dmi_target_fsm.sv
// Self-checking bench for dmi_target_fsm: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a transaction model.
module tb_dmi_target_fsm;
  import dmi_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [1:0]  dmi_req_op;
  logic [31:0] dmi_req_data;
  logic        dmi_resp_valid, dmi_resp_ready;
  logic [1:0]  dmi_resp_resp;
  logic [31:0] dmi_resp_data;
  logic        dm_req_valid, dm_req_ready;
  logic [6:0]  dm_addr;
  logic        dm_wen;
  logic [31:0] dm_wdata;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_rerr;

  dmi_target_fsm #(.ADDR_W(7), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_resp(dmi_resp_resp), .dmi_resp_data(dmi_resp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_rerr(dm_rerr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: which phase the single outstanding transaction is in,
  // and the response the spec's rules say it must produce.
  bit          m_live, m_after_rst;
  bit          m_ready, m_issue, m_wait, m_resp;
  int          m_wait_n;
  logic [6:0]  m_addr;
  bit          m_wen;
  logic [31:0] m_wdata;
  logic [1:0]  m_rresp;
  logic [31:0] m_rdata;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_after_rst = 1;
      m_ready = 0; m_issue = 0; m_wait = 0; m_resp = 0;
    end else begin
      m_after_rst = 0;
      if (m_resp) begin
        if (dmi_resp_ready) begin m_resp = 0; m_ready = 1; end
      end else if (m_issue) begin
        if (dm_req_ready) begin m_issue = 0; m_wait = 1; m_wait_n = 0; end
      end else if (m_wait) begin
        if (dm_rvalid) begin
          m_wait = 0; m_resp = 1;
          m_rresp = dm_rerr ? 2'd2 : 2'd0;
          m_rdata = (!m_wen && !dm_rerr) ? dm_rdata : 32'd0;
        end else begin
          m_wait_n++;
`ifdef DMI_TIMEOUT_EN
          if (m_wait_n >= TO) begin m_wait = 0; m_resp = 1; m_rresp = 2'd2; m_rdata = 0; end
`endif
        end
      end else if (m_ready && dmi_req_valid) begin
        m_ready = 0;
        m_addr = dmi_req_addr; m_wen = (dmi_req_op == 2'd2); m_wdata = dmi_req_data;
        m_rdata = 0;
        case (dmi_req_op)
          2'd1, 2'd2: m_issue = 1;
          2'd0: begin m_resp = 1; m_rresp = 2'd0; end
          default: begin m_resp = 1; m_rresp = 2'd2; end
        endcase
      end else begin
        m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("req_ready", dmi_req_ready, m_ready);
      chk("dm_req_valid", dm_req_valid, m_issue);
      chk("resp_valid", dmi_resp_valid, m_resp);
      if (m_issue) begin
        chk("dm_addr", dm_addr, m_addr);
        chk("dm_wen", dm_wen, m_wen);
        chk("dm_wdata", dm_wdata, m_wdata);
      end
      if (m_resp) begin
        chk("resp_code", dmi_resp_resp, m_rresp);
        chk("resp_data", dmi_resp_data, m_rdata);
      end
      if (m_after_rst) begin
        chk("rst_addr", dm_addr, 0);
        chk("rst_wen", dm_wen, 0);
        chk("rst_wdata", dm_wdata, 0);
        chk("rst_rresp", dmi_resp_resp, 0);
        chk("rst_rdata", dmi_resp_data, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    dmi_req_valid = 1; dmi_req_op = op; dmi_req_addr = a; dmi_req_data = d;
    tick();
    dmi_req_valid = 0;
  endtask

  // Read with immediate accept and completion one cycle later.
  task automatic quick_read(input string nm, input logic [6:0] a, input logic [31:0] rd);
    send(2'd1, a, 32'h0);
    chk({nm, "_dmvalid"}, dm_req_valid, 1);
    chk({nm, "_addr"}, dm_addr, a);
    chk({nm, "_wen"}, dm_wen, 0);
    dm_req_ready = 1; tick(); dm_req_ready = 0;
    dm_rvalid = 1; dm_rdata = rd; dm_rerr = 0; tick(); dm_rvalid = 0;
    chk({nm, "_rvalid"}, dmi_resp_valid, 1);
    chk({nm, "_resp"}, dmi_resp_resp, 0);
    chk({nm, "_data"}, dmi_resp_data, rd);
    dmi_resp_ready = 1; tick(); dmi_resp_ready = 0;
    chk({nm, "_ready_after"}, dmi_req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; dmi_req_valid = 0; dmi_req_addr = 0; dmi_req_op = 0; dmi_req_data = 0;
    dmi_resp_ready = 0; dm_req_ready = 0; dm_rvalid = 0; dm_rdata = 0; dm_rerr = 0;
    tick(); tick();
    chk("rst_req_ready", dmi_req_ready, 0);
    chk("rst_resp_valid", dmi_resp_valid, 0);
    chk("rst_dm_valid", dm_req_valid, 0);
    reset = 0; tick();
    chk("idle_ready", dmi_req_ready, 1);

    quick_read("read", 7'h11, 32'hDEADBEEF);

    // Write with accept stalled three cycles
    send(2'd2, 7'h10, 32'h80000001);
    for (int i = 0; i < 3; i++) begin
      chk("wr_hold_valid", dm_req_valid, 1);
      chk("wr_hold_addr", dm_addr, 7'h10);
      chk("wr_hold_wdata", dm_wdata, 32'h80000001);
      chk("wr_hold_wen", dm_wen, 1);
      tick();
    end
    dm_req_ready = 1; tick(); dm_req_ready = 0;
    dm_rvalid = 1; dm_rdata = 32'h12345678; tick(); dm_rvalid = 0;
    chk("wr_resp", dmi_resp_resp, 0);
    chk("wr_data", dmi_resp_data, 0);
    dmi_resp_ready = 1; tick(); dmi_resp_ready = 0;

    send(2'd0, 7'h05, 32'h1);
    chk("nop_valid", dmi_resp_valid, 1);
    chk("nop_resp", dmi_resp_resp, 0);
    chk("nop_nobus", dm_req_valid, 0);
    dmi_resp_ready = 1; tick(); dmi_resp_ready = 0;
    send(2'd3, 7'h05, 32'h1);
    chk("rsvd_resp", dmi_resp_resp, 2);
    chk("rsvd_data", dmi_resp_data, 0);
    chk("rsvd_nobus", dm_req_valid, 0);
    dmi_resp_ready = 1; tick(); dmi_resp_ready = 0;

    // Error completion under response back-pressure
    send(2'd1, 7'h20, 32'h0);
    dm_req_ready = 1; tick(); dm_req_ready = 0;
    dm_rvalid = 1; dm_rerr = 1; dm_rdata = 32'hFFFF0000; tick(); dm_rvalid = 0; dm_rerr = 0;
    for (int i = 0; i < 5; i++) begin
      chk("err_valid", dmi_resp_valid, 1);
      chk("err_resp", dmi_resp_resp, 2);
      chk("err_data", dmi_resp_data, 0);
      chk("err_req_ready", dmi_req_ready, 0);
      tick();
    end
    chk("err_fire_ready", dmi_req_ready, 0);
    dmi_resp_ready = 1; tick(); dmi_resp_ready = 0;
    chk("err_after_ready", dmi_req_ready, 1);

    // Reset while waiting for completion, then a stray completion
    send(2'd1, 7'h33, 32'h0);
    dm_req_ready = 1; tick(); dm_req_ready = 0;
    reset = 1; tick(); reset = 0;
    chk("mid_rst_dmvalid", dm_req_valid, 0);
    chk("mid_rst_addr", dm_addr, 0);
    chk("mid_rst_rvalid", dmi_resp_valid, 0);
    chk("mid_rst_ready", dmi_req_ready, 0);
    dm_rvalid = 1; dm_rdata = 32'hAAAA5555; tick(); dm_rvalid = 0;
    chk("stray_noresp", dmi_resp_valid, 0);
    chk("stray_ready", dmi_req_ready, 1);
    tick();
    chk("stray_noresp2", dmi_resp_valid, 0);
    quick_read("post_rst", 7'h22, 32'h0BADF00D);

`ifdef DMI_TIMEOUT_EN
    begin
      int k;
      send(2'd1, 7'h44, 32'h0);
      dm_req_ready = 1; tick(); dm_req_ready = 0;
      k = 0;
      while (k < 20 && !dmi_resp_valid) begin tick(); k++; end
      chk("to_latency", k, TO);
      chk("to_resp", dmi_resp_resp, 2);
      chk("to_data", dmi_resp_data, 0);
      dmi_resp_ready = 1; tick(); dmi_resp_ready = 0;
      dm_rvalid = 1; dm_rdata = 32'h77; tick(); dm_rvalid = 0;
      for (int i = 0; i < 3; i++) begin
        chk("to_late_noresp", dmi_resp_valid, 0);
        tick();
      end
    end
`endif

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 255) == 0);
      dmi_req_valid  = $urandom_range(0, 1);
      dmi_req_op     = 2'($urandom_range(0, 3));
      dmi_req_addr   = 7'($urandom);
      dmi_req_data   = $urandom;
      dm_req_ready   = $urandom_range(0, 1);
      dm_rvalid      = ($urandom_range(0, 9) < 3);
      dm_rdata       = $urandom;
      dm_rerr        = ($urandom_range(0, 3) == 0);
      dmi_resp_ready = $urandom_range(0, 1);
      tick();
    end
    reset = 0; dmi_req_valid = 0; dm_rvalid = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
